// File: rtl/ni_injection_arbiter.sv
// Packet-atomic round-robin arbiter sharing the router LOCAL injection port among
// the network interface's per-VC flit sources; one registered flit per cycle.
package ni_injection_arbiter_pkg;
  localparam int VC_PER_PORT = 4;
  localparam int VC_W        = (VC_PER_PORT > 1) ? $clog2(VC_PER_PORT) : 1;
  localparam int PAYLOAD_W   = 32;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2,
    HT     = 2'd3
  } flit_type_t;

  typedef struct packed {
    flit_type_t            flit_type;
    logic [VC_W-1:0]       vc;
    logic [PAYLOAD_W-1:0]  payload;
  } flit_t;
endpackage

module ni_injection_arbiter
  import ni_injection_arbiter_pkg::*;
#(
  parameter int VC_NUM = VC_PER_PORT,
  parameter int CNT_W  = 16,
  localparam int IDX_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  // Handshake: src_flit_valid[v] offers src_flit[v]; a src_flit_consumed[v] pulse
  // in the same cycle means the flit was taken at this edge and the source must
  // present its next flit (or drop valid) in the following cycle.
  input  logic [VC_NUM-1:0]             src_flit_valid,
  input  flit_t [VC_NUM-1:0]            src_flit,
  output logic [VC_NUM-1:0]             src_flit_consumed,
  input  logic [VC_NUM-1:0]             router_credit,
  output flit_t                         ni_flit_out,
  output logic                          ni_flit_out_valid,
  output logic [VC_NUM-1:0][CNT_W-1:0]  stall_count,
  // {lock_valid, lock_vc, rr_last}
  output logic [2*IDX_W:0]              debug_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] LAST_VC = IDX_W'(VC_NUM - 1);

  logic               lock_valid;
  logic [IDX_W-1:0]   lock_vc;
  logic [IDX_W-1:0]   rr_last;

  logic [VC_NUM-1:0]  eligible;
  logic [VC_NUM-1:0]  grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  flit_t              grant_flit;

  always_comb begin
    eligible  = src_flit_valid & ~router_credit & {VC_NUM{enable}};
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (!reset) begin
      if (lock_valid) begin
        if (eligible[lock_vc]) begin
          grant_any = 1'b1;
          grant_idx = lock_vc;
        end
      end else begin
        // Scan farthest-to-nearest from rr_last so the nearest eligible VC is written last and wins.
        for (int k = VC_NUM; k >= 1; k--) begin
          if (eligible[(int'(rr_last) + k) % VC_NUM]) begin
            grant_any = 1'b1;
            grant_idx = IDX_W'((int'(rr_last) + k) % VC_NUM);
          end
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  assign grant_flit        = src_flit[grant_idx];
  assign src_flit_consumed = grant;
  assign debug_state       = {lock_valid, lock_vc, rr_last};

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid        <= 1'b0;
      lock_vc           <= '0;
      rr_last           <= LAST_VC;
      ni_flit_out       <= '0;
      ni_flit_out_valid <= 1'b0;
    end else begin
      ni_flit_out_valid <= grant_any;
      if (grant_any) begin
        ni_flit_out <= grant_flit;
        rr_last     <= grant_idx;
        if (lock_valid) begin
          if (grant_flit.flit_type == TAIL) lock_valid <= 1'b0;
        end else if (grant_flit.flit_type == HEADER) begin
          lock_valid <= 1'b1;
          lock_vc    <= grant_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (reset || grant[v]) begin
        stall_count[v] <= '0;
      end else if (src_flit_valid[v] && stall_count[v] != CNT_MAX) begin
        stall_count[v] <= stall_count[v] + 1'b1;
      end
    end
  end

  // Source protocol: unlocked grants must start a packet, locked grants must continue one.
  always_ff @(posedge clk) begin
    if (!reset && grant_any) begin
      if (!lock_valid) assert (grant_flit.flit_type == HEADER || grant_flit.flit_type == HT);
      else             assert (grant_flit.flit_type != HEADER);
    end
  end

endmodule

// File: tb/tb_ni_injection_arbiter.sv
// Randomized and directed bench for ni_injection_arbiter: queue-based sources, a
// reference model of the arbitration rules, and a scoreboard on the output link.
module tb_ni_injection_arbiter;
  import ni_injection_arbiter_pkg::*;

  localparam int VC     = 4;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = 2;
  localparam int FLIT_W = $bits(flit_t);
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      enable;
  logic [VC-1:0]             src_flit_valid;
  flit_t [VC-1:0]            src_flit;
  logic [VC-1:0]             src_flit_consumed;
  logic [VC-1:0]             router_credit;
  flit_t                     ni_flit_out;
  logic                      ni_flit_out_valid;
  logic [VC-1:0][CNT_W-1:0]  stall_count;
  logic [2*IDX_W:0]          debug_state;

  ni_injection_arbiter #(.VC_NUM(VC), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .src_flit_valid    (src_flit_valid),
    .src_flit          (src_flit),
    .src_flit_consumed (src_flit_consumed),
    .router_credit     (router_credit),
    .ni_flit_out       (ni_flit_out),
    .ni_flit_out_valid (ni_flit_out_valid),
    .stall_count       (stall_count),
    .debug_state       (debug_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // stimulus state
  flit_t          src_q[VC][$];
  logic [VC-1:0]  hold = '0;
  logic [VC-1:0]  cr   = '0;
  logic           en   = 1'b1;
  logic           rst  = 1'b1;

  // reference model state
  int  m_rr      = VC - 1;
  bit  m_lock    = 1'b0;
  int  m_lock_vc = 0;
  int  m_cnt[VC];
  bit  primed    = 1'b0;

  logic [FLIT_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic push_pkt(input int v, input int nbody, input bit single);
    flit_t f;
    f.vc = VC_W'(v);
    if (single) begin
      f.flit_type = HT; f.payload = $urandom; src_q[v].push_back(f);
    end else begin
      f.flit_type = HEADER; f.payload = $urandom; src_q[v].push_back(f);
      for (int i = 0; i < nbody; i++) begin
        f.flit_type = BODY; f.payload = $urandom; src_q[v].push_back(f);
      end
      f.flit_type = TAIL; f.payload = $urandom; src_q[v].push_back(f);
    end
  endtask

  function automatic logic [VC-1:0] offered();
    logic [VC-1:0] o;
    for (int v = 0; v < VC; v++) o[v] = (src_q[v].size() > 0) && !hold[v];
    return o;
  endfunction

  task automatic drive();
    src_flit_valid = offered();
    for (int v = 0; v < VC; v++) src_flit[v] = (src_q[v].size() > 0) ? src_q[v][0] : '0;
    router_credit = cr;
    enable        = en;
    reset         = rst;
  endtask

  // One cycle: drive after the edge, then check and advance the model mid-cycle.
  task automatic step();
    logic [VC-1:0] vld, elig, want;
    int g;
    flit_t f;
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    vld  = offered();
    elig = vld & ~cr & {VC{en}};
    g    = -1;
    if (!rst) begin
      if (m_lock) begin
        if (elig[m_lock_vc]) g = m_lock_vc;
      end else begin
        for (int k = 1; k <= VC; k++) begin
          if (elig[(m_rr + k) % VC]) begin
            g = (m_rr + k) % VC;
            break;
          end
        end
      end
    end
    want = '0;
    if (g >= 0) want[g] = 1'b1;
    chk("consumed", 64'(src_flit_consumed), 64'(want));
    if (primed)
      for (int v = 0; v < VC; v++) chk($sformatf("stall_count[%0d]", v), 64'(stall_count[v]), 64'(m_cnt[v]));
    for (int v = 0; v < VC; v++) begin
      if (rst || v == g) m_cnt[v] = 0;
      else if (vld[v] && m_cnt[v] < CMAX) m_cnt[v]++;
    end
    if (g >= 0) begin
      f = src_q[g].pop_front();
      exp_q.push_back(f);
      m_rr = g;
      if (m_lock) begin
        if (f.flit_type == TAIL) m_lock = 1'b0;
      end else if (f.flit_type == HEADER) begin
        m_lock = 1'b1;
        m_lock_vc = g;
      end
    end
    if (rst) begin
      m_lock = 1'b0;
      m_rr   = VC - 1;
      primed = 1'b1;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_sources();
    for (int v = 0; v < VC; v++) src_q[v].delete();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [FLIT_W-1:0] e;
    if (ni_flit_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL flit_out: got %h want none (t=%0t)", ni_flit_out, $time);
      end else begin
        e = exp_q.pop_front();
        chk("flit_out", 64'(ni_flit_out), 64'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    for (int v = 0; v < VC; v++) m_cnt[v] = 0;
    reset = 1'b1; enable = 1'b1; src_flit_valid = '0; src_flit = '0; router_credit = '0;

    // reset state
    rst = 1'b1;
    steps(2);
    chk("reset_valid", 64'(ni_flit_out_valid), 64'(0));
    chk("reset_flit", 64'(ni_flit_out), 64'(0));
    rst = 1'b0;

    // single HT per VC, round-robin after reset
    for (int v = 0; v < VC; v++) push_pkt(v, 0, 1'b1);
    steps(6);

    // packet atomicity against a continuously requesting VC0
    push_pkt(1, 2, 1'b0);
    step();
    for (int i = 0; i < 3; i++) push_pkt(0, 0, 1'b1);
    steps(10);

    // backpressure mid-packet
    push_pkt(2, 1, 1'b0);
    push_pkt(3, 0, 1'b1);
    step();
    cr[2] = 1'b1;
    steps(3);
    cr[2] = 1'b0;
    steps(5);

    // enable gating mid-packet
    push_pkt(1, 2, 1'b0);
    steps(2);
    en = 1'b0;
    steps(2);
    en = 1'b1;
    steps(6);

    // reset mid-packet
    push_pkt(0, 1, 1'b0);
    step();
    rst = 1'b1;
    step();
    clear_sources();
    rst = 1'b0;
    push_pkt(0, 0, 1'b1);
    push_pkt(1, 0, 1'b1);
    steps(4);

    // counter saturation behind a long packet
    push_pkt(0, 18, 1'b0);
    step();
    push_pkt(3, 0, 1'b1);
    steps(25);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      for (int v = 0; v < VC; v++) begin
        if (src_q[v].size() < 4 && $urandom_range(0, 3) == 0)
          push_pkt(v, $urandom_range(0, 3), $urandom_range(0, 2) == 0);
        hold[v] = ($urandom_range(0, 9) == 0);
        cr[v]   = ($urandom_range(0, 4) == 0);
      end
      en = ($urandom_range(0, 9) != 0);
      step();
    end

    // drain
    hold = '0; cr = '0; en = 1'b1;
    guard = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()) > 0 && guard < 2000) begin
      step();
      guard++;
    end
    chk("drain_timeout", 64'(guard < 2000), 64'(1));
    steps(3);
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
